register_bank: RTL and testbench

REGISTER_BANK -- requirements
Module: register_bank

---
 rtl/register_bank.sv | 125 ++++++++++++
 tb/tb_register_bank.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/register_bank.sv
// register_bank: multi-entry register file with two registered read ports,
// one write port with write-first forwarding, and a ready/valid dump engine
// that streams every entry out in address order.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = '1;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DATA_WIDTH-1:0] regs_d [DEPTH];
    logic [DATA_WIDTH-1:0] data_a_q, data_a_d;
    logic [DATA_WIDTH-1:0] data_b_q, data_b_d;
    logic [0:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] dump_data_q, dump_data_d;
    logic                  done_q, done_d;
    logic                  wr_en;

    // Entry 0 is read-only zero when ZERO_REG is set, so its writes are dropped here.
    assign wr_en = reg_write && !((ZERO_REG != 0) && (write_address == '0));

    // Write-first read of one entry: a same-cycle write to that entry wins.
    function automatic logic [DATA_WIDTH-1:0] rd_fwd(input logic [ADDR_WIDTH-1:0] a);
        if ((ZERO_REG != 0) && (a == '0))
            return '0;
        if (wr_en && (write_address == a))
            return write_data;
        return regs_q[a];
    endfunction

    // Next-state for storage and the two read ports.
    always_comb begin
        for (int i = 0; i < DEPTH; i++)
            regs_d[i] = regs_q[i];
        if (wr_en)
            regs_d[write_address] = write_data;
        data_a_d = rd_fwd(read_addr_a);
        data_b_d = rd_fwd(read_addr_b);
    end

    // Dump engine: IDLE waits for dump_start, SEND presents one entry per beat
    // and only advances when the consumer takes it, so a stalled beat stays frozen.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        dump_data_d = dump_data_q;
        done_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_start) begin
                    state_d     = SEND;
                    idx_d       = '0;
                    dump_data_d = rd_fwd('0);
                end
            end
            default: begin
                if (dump_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d       = idx_q + 1'b1;
                        dump_data_d = rd_fwd(idx_q + 1'b1);
                    end
                end
            end
        endcase
    end

    // State registers; reset clears every entry and aborts any dump silently.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= '0;
            data_a_q    <= '0;
            data_b_q    <= '0;
            state_q     <= IDLE;
            idx_q       <= '0;
            dump_data_q <= '0;
            done_q      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                regs_q[i] <= regs_d[i];
            data_a_q    <= data_a_d;
            data_b_q    <= data_b_d;
            state_q     <= state_d;
            idx_q       <= idx_d;
            dump_data_q <= dump_data_d;
            done_q      <= done_d;
        end
    end

    assign data_a     = data_a_q;
    assign data_b     = data_b_q;
    assign dump_valid = (state_q == SEND);
    assign dump_busy  = (state_q != IDLE);
    assign dump_addr  = idx_q;
    assign dump_data  = dump_data_q;
    assign dump_done  = done_q;

endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: directed vectors with hand-computed expectations for the
// register file, forwarding, zero entry, full dump, backpressure and reset abort.
module tb_register_bank;
    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [4:0]  read_addr_a = '0, read_addr_b = '0, write_address = '0;
    logic [31:0] write_data = '0;
    logic        reg_write = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
    logic [31:0] data_a, data_b, dump_data;
    logic [4:0]  dump_addr;
    logic        dump_valid, dump_busy, dump_done;

    int n_chk = 0;
    int n_err = 0;

    register_bank #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1)) dut (
        .clock(clock), .reset_n(reset_n),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .data_a(data_a), .data_b(data_b),
        .write_address(write_address), .write_data(write_data), .reg_write(reg_write),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst data_a", data_a, 0);
        chk("rst data_b", data_b, 0);
        chk("rst valid", {31'd0, dump_valid}, 0);
        chk("rst busy", {31'd0, dump_busy}, 0);
        chk("rst done", {31'd0, dump_done}, 0);
        chk("rst dump_addr", {27'd0, dump_addr}, 0);
        chk("rst dump_data", dump_data, 0);
        tick();
        tick();
        reset_n = 1'b1;

        // Basic write then read (first write lands on first edge after reset)
        reg_write = 1'b1; write_address = 5'd1; write_data = 32'h0000_000A;
        tick();
        reg_write = 1'b0; read_addr_a = 5'd1;
        tick();
        chk("rd addr1", data_a, 32'h0000_000A);

        // Same-cycle write/read forwarding on port B
        reg_write = 1'b1; write_address = 5'd16; write_data = 32'hAAAA_AAAA; read_addr_b = 5'd16;
        tick();
        chk("fwd addr16", data_b, 32'hAAAA_AAAA);

        // Zero entry ignores writes, including the forwarding path
        write_address = 5'd0; write_data = 32'hFFFF_FFFF; read_addr_a = 5'd0;
        tick();
        chk("zero fwd", data_a, 0);
        reg_write = 1'b0;
        tick();
        chk("zero rd", data_a, 0);
        reg_write = 1'b0;
        read_addr_b = 5'd16;
        tick();
        chk("rd addr16", data_b, 32'hAAAA_AAAA);

        // Preload n+100
        for (int n = 0; n < 32; n++) begin
            reg_write = 1'b1; write_address = 5'(n); write_data = 32'(n + 100);
            tick();
        end
        reg_write = 1'b0;
        read_addr_a = 5'd1; read_addr_b = 5'd31;
        tick();
        chk("pre addr1", data_a, 32'd101);
        chk("pre addr31", data_b, 32'd131);

        // Full dump with dump_ready held high
        dump_ready = 1'b1; dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 0; b < 32; b++) begin
            chk("dump valid", {31'd0, dump_valid}, 1);
            chk("dump addr", {27'd0, dump_addr}, 32'(b));
            chk("dump data", dump_data, (b == 0) ? 32'd0 : 32'(b + 100));
            chk("dump done early", {31'd0, dump_done}, 0);
            tick();
        end
        chk("end done", {31'd0, dump_done}, 1);
        chk("end busy", {31'd0, dump_busy}, 0);
        chk("end valid", {31'd0, dump_valid}, 0);
        tick();
        chk("done one cycle", {31'd0, dump_done}, 0);

        // Backpressure at index 5 with writes to the held and the next entry
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        for (int b = 0; b < 5; b++) tick();
        dump_ready = 1'b0;
        chk("bp addr5", {27'd0, dump_addr}, 5);
        chk("bp data5", dump_data, 32'd105);
        reg_write = 1'b1; write_address = 5'd5; write_data = 32'h55;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        chk("hold addr", {27'd0, dump_addr}, 5);
        chk("hold data", dump_data, 32'd105);
        chk("hold valid", {31'd0, dump_valid}, 1);
        write_address = 5'd6; write_data = 32'h66; read_addr_a = 5'd5;
        tick();
        chk("hold2 data", dump_data, 32'd105);
        chk("rd during dump", data_a, 32'h55);
        dump_ready = 1'b1; reg_write = 1'b0;
        tick();
        chk("next addr6", {27'd0, dump_addr}, 6);
        chk("next data66", dump_data, 32'h66);

        // Advance to index 10, stall, then reset mid-dump
        for (int b = 0; b < 4; b++) tick();
        dump_ready = 1'b0;
        chk("idx10", {27'd0, dump_addr}, 10);
        chk("idx10 data", dump_data, 32'd110);
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort valid", {31'd0, dump_valid}, 0);
        chk("abort busy", {31'd0, dump_busy}, 0);
        chk("abort done", {31'd0, dump_done}, 0);
        chk("abort addr", {27'd0, dump_addr}, 0);
        chk("abort data_a", data_a, 0);
        dump_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        chk("post rst done", {31'd0, dump_done}, 0);
        read_addr_a = 5'd5; read_addr_b = 5'd6;
        tick();
        chk("cleared addr5", data_a, 0);
        chk("cleared addr6", data_b, 0);
        chk("post rst done2", {31'd0, dump_done}, 0);
        chk("post rst busy", {31'd0, dump_busy}, 0);
        read_addr_a = 5'd31; read_addr_b = 5'd16;
        tick();
        chk("cleared addr31", data_a, 0);
        chk("cleared addr16", data_b, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end
endmodule
